// File: rtl/fp_scaleb16_arb.sv
// Round-robin front end that shares one LAT-deep FP16 scaleb pipeline among NREQ requesters.
// Issued ops are tagged through the pipe and their results land in per-requester result FIFOs.
module fp_scaleb16_arb #(
  parameter int NREQ   = 4,
  parameter int LAT    = 2,
  parameter int RDEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [16*NREQ-1:0]   resp_o,
  output logic                 su_ce,
  output logic [15:0]          su_a,
  output logic [15:0]          su_b,
  input  logic [15:0]          su_o,
  output logic                 busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW  = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int CW  = $clog2(RDEPTH + 1);

  logic [IDW-1:0]  ptr_r;
  logic [LAT-1:0]  tag_vld_r;
  logic [IDW-1:0]  tag_id_r [LAT];
  logic [CW-1:0]   cnt_r    [NREQ];
  logic [CW-1:0]   fill_r   [NREQ];
  logic [AW-1:0]   wptr_r   [NREQ];
  logic [AW-1:0]   rptr_r   [NREQ];
  logic [15:0]     mem_r    [NREQ][RDEPTH];

  logic [NREQ-1:0] elig_s;
  logic [NREQ-1:0] grant_s;
  logic [NREQ-1:0] wr_s;
  logic [NREQ-1:0] pop_s;
  logic            grant_any_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [IDW:0]    idx_s;
  logic            retire_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (RDEPTH == 1) ? {AW{1'b0}} : p + 1'b1;
  endfunction

  // Per-requester eligibility, FIFO status, write/pop strobes and busy.
  always_comb begin
    retire_s   = ce & tag_vld_r[LAT-1];
    elig_s     = '0;
    resp_valid = '0;
    pop_s      = '0;
    wr_s       = '0;
    resp_o     = '0;
    busy       = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // cnt covers in-flight plus queued ops, so a grant can never overflow the FIFO.
      elig_s[i]        = rst_n & ce & req_valid[i] & (cnt_r[i] < CW'(RDEPTH));
      resp_valid[i]    = (fill_r[i] != '0);
      pop_s[i]         = resp_valid[i] & resp_ready[i];
      wr_s[i]          = retire_s & (tag_id_r[LAT-1] == IDW'(i));
      resp_o[16*i +: 16] = resp_valid[i] ? mem_r[i][rptr_r[i]] : 16'h0000;
      busy             = busy | (cnt_r[i] != '0);
    end
  end

  // Round-robin search starting at ptr_r, wrapping modulo NREQ.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    idx_s       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, ptr_r} + (IDW+1)'(k);
      idx_s = (idx_s >= (IDW+1)'(NREQ)) ? idx_s - (IDW+1)'(NREQ) : idx_s;
      grant_idx_s = (!grant_any_s && elig_s[idx_s[IDW-1:0]]) ? idx_s[IDW-1:0] : grant_idx_s;
      grant_any_s = grant_any_s | elig_s[idx_s[IDW-1:0]];
    end
  end

  // Grant vector and operand steering to the shared unit.
  always_comb begin
    grant_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_s[i] = grant_any_s & (grant_idx_s == IDW'(i));
    end
    req_ready = grant_s;
    su_ce     = ce;
    su_a      = grant_any_s ? req_a[16*grant_idx_s +: 16] : 16'h0000;
    su_b      = grant_any_s ? req_b[16*grant_idx_s +: 16] : 16'h0000;
  end

  // Pointer, tag pipeline, credit counters and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= '0;
      tag_vld_r <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_id_r[s] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        cnt_r[i]  <= '0;
        fill_r[i] <= '0;
        wptr_r[i] <= '0;
        rptr_r[i] <= '0;
      end
    end else begin
      if (grant_any_s) begin
        ptr_r <= (grant_idx_s == IDW'(NREQ - 1)) ? '0 : grant_idx_s + 1'b1;
      end
      // Tags advance in lockstep with the unit, which only moves when ce is high.
      if (ce) begin
        tag_vld_r[0] <= grant_any_s;
        tag_id_r[0]  <= grant_idx_s;
        for (int s = 1; s < LAT; s++) begin
          tag_vld_r[s] <= tag_vld_r[s-1];
          tag_id_r[s]  <= tag_id_r[s-1];
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        case ({grant_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + 1'b1;
          2'b01:   cnt_r[i] <= cnt_r[i] - 1'b1;
          default: cnt_r[i] <= cnt_r[i];
        endcase
        case ({wr_s[i], pop_s[i]})
          2'b10:   fill_r[i] <= fill_r[i] + 1'b1;
          2'b01:   fill_r[i] <= fill_r[i] - 1'b1;
          default: fill_r[i] <= fill_r[i];
        endcase
        if (wr_s[i]) begin
          wptr_r[i] <= ptr_inc(wptr_r[i]);
        end
        if (pop_s[i]) begin
          rptr_r[i] <= ptr_inc(rptr_r[i]);
        end
      end
    end
  end

  // Result storage; contents are only observable while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (wr_s[i]) begin
        mem_r[i][wptr_r[i]] <= su_o;
      end
    end
  end

endmodule

// File: tb/tb_fp_scaleb16_arb.sv
// Bench for fp_scaleb16_arb: behavioural scaleb unit, cycle-level arbitration model and a
// result scoreboard popped by an independent monitor.
module tb_fp_scaleb16_arb;
  localparam int NREQ   = 4;
  localparam int LAT    = 2;
  localparam int RDEPTH = 2;

  logic                clk = 1'b0;
  logic                rst_n, ce;
  logic [NREQ-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [16*NREQ-1:0]  req_a, req_b, resp_o;
  logic                su_ce, busy;
  logic [15:0]         su_a, su_b, su_o;

  fp_scaleb16_arb #(.NREQ(NREQ), .LAT(LAT), .RDEPTH(RDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_o(resp_o),
    .su_ce(su_ce), .su_a(su_a), .su_b(su_b), .su_o(su_o), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // FP16 a * 2^b with b as a signed integer; overflow saturates to inf, tiny results truncate.
  function automatic logic [15:0] scaleb16(input logic [15:0] a, input logic [15:0] b);
    int e, m, sh;
    logic s;
    s = a[15];
    e = int'(a[14:10]);
    m = int'(a[9:0]);
    if (e == 31 || (e == 0 && m == 0)) return a;
    if (e == 0) begin
      e = 1;
      while (m < 1024) begin m = m * 2; e = e - 1; end
    end else begin
      m = m + 1024;
    end
    e = e + int'($signed(b));
    if (e >= 31) return {s, 15'h7C00};
    if (e >= 1) return {s, 5'(e), 10'(m % 1024)};
    sh = 1 - e;
    if (sh > 11) return {s, 15'h0000};
    return {s, 5'h00, 10'(m >> sh)};
  endfunction

  // Shared scaleb unit: LAT ce-gated stages, no valid.
  logic [15:0] pipe [LAT];
  always @(posedge clk) begin
    if (su_ce) begin
      pipe[0] <= scaleb16(su_a, su_b);
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
  end
  assign su_o = pipe[LAT-1];

  typedef struct packed { logic [7:0] id; logic [15:0] d; } ent_t;
  ent_t exp_q[$];

  // Arbitration / occupancy model: checks the pre-edge outputs, then advances to the next edge.
  int cnt_m [NREQ];
  int occ_m [NREQ];
  int ptr_m;
  int fl_cd[$], fl_id[$];
  always @(negedge clk) begin : issue_model
    int g, idx;
    int ncd[$], nid[$];
    logic [NREQ-1:0] exp_rdy, exp_rv;
    logic            exp_busy;
    logic [15:0]     ea, eb;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_o", resp_o, 0);
      chk("rst_busy", busy, 0);
      for (int i = 0; i < NREQ; i++) begin cnt_m[i] = 0; occ_m[i] = 0; end
      ptr_m = 0;
      fl_cd.delete();
      fl_id.delete();
    end else begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr_m + k) % NREQ;
        if (g < 0 && ce && req_valid[idx] && cnt_m[idx] < RDEPTH) g = idx;
      end
      exp_rdy = '0; exp_rv = '0; exp_busy = 1'b0; ea = 16'h0000; eb = 16'h0000;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        ea = req_a[16*g +: 16];
        eb = req_b[16*g +: 16];
      end
      for (int i = 0; i < NREQ; i++) begin
        exp_rv[i] = (occ_m[i] != 0);
        if (cnt_m[i] != 0) exp_busy = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("su_ce", su_ce, ce);
      chk("su_a", su_a, ea);
      chk("su_b", su_b, eb);
      chk("resp_valid", resp_valid, exp_rv);
      chk("busy", busy, exp_busy);
      for (int i = 0; i < NREQ; i++) begin
        if (occ_m[i] > 0 && resp_ready[i]) begin occ_m[i]--; cnt_m[i]--; end
      end
      if (ce) begin
        ncd.delete(); nid.delete();
        for (int j = 0; j < fl_cd.size(); j++) begin
          if (fl_cd[j] == 1) occ_m[fl_id[j]]++;
          else begin ncd.push_back(fl_cd[j] - 1); nid.push_back(fl_id[j]); end
        end
        fl_cd = ncd;
        fl_id = nid;
      end
      if (g >= 0) begin
        fl_cd.push_back(LAT);
        fl_id.push_back(g);
        cnt_m[g]++;
        ptr_m = (g + 1) % NREQ;
        exp_q.push_back('{id: 8'(g), d: scaleb16(ea, eb)});
      end
    end
  end

  // Result monitor: every pop must match the oldest outstanding result for that requester.
  always @(negedge clk) begin : resp_monitor
    int hit;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          hit = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (hit < 0 && exp_q[j].id == 8'(i)) hit = j;
          if (hit < 0) begin
            n_checks++;
            $display("FAIL resp_unexpected: requester %0d popped %0h with nothing outstanding", i, resp_o[16*i +: 16]);
          end else begin
            chk("resp_data", resp_o[16*i +: 16], exp_q[hit].d);
            exp_q.delete(hit);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input logic [NREQ-1:0] v);
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'($urandom);
      req_b[16*i +: 16] = 16'($urandom_range(0, 40)) - 16'd20;
    end
  endtask

  // Issue every currently valid request exactly once.
  task automatic issue_all();
    logic [NREQ-1:0] nxt;
    int guard = 0;
    while (req_valid != '0 && guard < 20) begin
      #2;
      nxt = req_valid & ~req_ready;
      step();
      req_valid = nxt;
      guard++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, acc1;
    rst_n = 1'b0; ce = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
    repeat (3) step();
    rst_n = 1'b1; ce = 1'b1; resp_ready = '1;
    step();

    // Single request: 1.0 * 2^2 = 4.0
    req_valid = 4'b0001; req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h0002;
    step();
    req_valid = '0;
    lat = 1;
    while (!resp_valid[0] && lat < 20) begin step(); lat++; end
    chk("single_latency", lat, LAT + 1);
    chk("single_data", resp_o[15:0], 16'h4400);
    step();
    chk("single_busy_drop", busy, 1'b0);

    // All requesters continuously valid.
    for (int c = 0; c < 40; c++) begin rand_ops('1); step(); end
    req_valid = '0;
    repeat (10) step();

    // Backpressure on requester 1.
    resp_ready = 4'b1101;
    acc1 = 0;
    for (int c = 0; c < 20; c++) begin
      rand_ops('1);
      #2;
      if (req_ready[1]) acc1++;
      step();
    end
    chk("bp_accepts_r1", acc1, RDEPTH);
    resp_ready = '1;
    for (int c = 0; c < 12; c++) begin rand_ops('1); step(); end
    req_valid = '0;
    repeat (10) step();

    // ce freeze with two ops in flight.
    rand_ops(4'b0100);
    step();
    lat = 1;
    rand_ops(4'b1000);
    step();
    lat++;
    req_valid = '0; ce = 1'b0;
    repeat (3) begin step(); lat++; end
    ce = 1'b1;
    while (!resp_valid[2] && lat < 30) begin step(); lat++; end
    chk("freeze_latency", lat, LAT + 1 + 3);
    repeat (6) step();

    // Overflow and NaN pass through.
    resp_ready = '0;
    req_a[15:0] = 16'h7800; req_b[15:0] = 16'h0010;
    req_a[31:16] = 16'h7E00; req_b[31:16] = 16'h0005;
    req_valid = 4'b0011;
    issue_all();
    repeat (6) step();
    chk("special_valid", resp_valid[1:0], 2'b11);
    chk("overflow_inf", resp_o[15:0], 16'h7C00);
    chk("nan_pass", resp_o[31:16], 16'h7E00);
    resp_ready = '1;
    repeat (4) step();

    // Reset with one queued result and two ops in flight.
    resp_ready = '0;
    rand_ops(4'b0001);
    step();
    req_valid = '0;
    repeat (4) step();
    rand_ops(4'b0010);
    step();
    rand_ops(4'b0100);
    step();
    req_valid = '0;
    chk("pre_rst_queued", resp_valid[0], 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_now_resp_valid", resp_valid, 0);
    chk("rst_now_busy", busy, 0);
    repeat (2) step();
    rst_n = 1'b1;
    resp_ready = '1;
    repeat (5) step();
    rand_ops('1);
    #2;
    chk("post_rst_ptr0", req_ready, 4'b0001);
    step();

    // Random traffic with ce gaps and random backpressure.
    for (int c = 0; c < 300; c++) begin
      rand_ops(NREQ'($urandom));
      resp_ready = NREQ'($urandom);
      ce = ($urandom_range(0, 9) != 0);
      step();
    end
    req_valid = '0; resp_ready = '1; ce = 1'b1;
    repeat (20) step();
    chk("drain_busy", busy, 1'b0);
    chk("drain_scoreboard", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
